// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mult_state_t;

  typedef enum logic [2:0] {
    SelZero,
    SelPos1,
    SelPos2,
    SelNeg1,
    SelNeg2
  } booth_sel_t;

  // Number of Booth digits needed for a width-bit operand extended by two bits.
  function automatic int unsigned niter(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: {b[2i+1], b[2i], b[2i-1]} -> digit in {-2..+2}.
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0] window,
  output booth_sel_t sel
);

  always_comb begin
    sel = SelZero;
    unique case (window)
      3'b000, 3'b111: sel = SelZero;
      3'b001, 3'b010: sel = SelPos1;
      3'b011:         sel = SelPos2;
      3'b100:         sel = SelNeg2;
      3'b101, 3'b110: sel = SelNeg1;
      default:        sel = SelZero;
    endcase
  end

endmodule

// File: rtl/mult_seq_booth.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional MULT_SEQ_ZERO_SKIP_EN: zero operands bypass the iteration loop.
module mult_seq_booth
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PROD_W = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              signed_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  localparam int unsigned NITER = niter(WIDTH);
  localparam int unsigned ACC_W = PROD_W + 4;
  localparam int unsigned CNT_W = $clog2(NITER + 1);
  localparam int unsigned BX_W  = WIDTH + 2;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("mult_seq_booth: WIDTH must be even and >= 4");
  end
  if (PROD_W != 2 * WIDTH) begin : g_bad_prod_w
    $error("mult_seq_booth: PROD_W must equal 2*WIDTH");
  end

  mult_state_t       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  a_sh_q, a_sh_d;
  logic [BX_W-1:0]   b_sh_q, b_sh_d;
  logic              b_prev_q, b_prev_d;
  logic [CNT_W-1:0]  iter_q, iter_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic              out_valid_q, out_valid_d;

  booth_sel_t       sel;
  logic [ACC_W-1:0] addend;

  booth_r4_encoder u_enc (
    .window ({b_sh_q[1:0], b_prev_q}),
    .sel    (sel)
  );

  // a_sh_q already carries the 2i shift; b_sh_q is consumed two bits per step.
  always_comb begin
    addend = '0;
    case (sel)
      SelPos1: addend = a_sh_q;
      SelPos2: addend = a_sh_q << 1;
      SelNeg1: addend = -a_sh_q;
      SelNeg2: addend = -(a_sh_q << 1);
      default: addend = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    b_prev_d    = b_prev_q;
    iter_d      = iter_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d   = {{(ACC_W - WIDTH){signed_mode & a[WIDTH-1]}}, a};
          b_sh_d   = {{2{signed_mode & b[WIDTH-1]}}, b};
          b_prev_d = 1'b0;
          acc_d    = '0;
          iter_d   = '0;
          state_d  = StBusy;
`ifdef MULT_SEQ_ZERO_SKIP_EN
          // Cleared accumulator already holds the answer; DONE loads it next edge.
          if (a == '0 || b == '0) state_d = StDone;
`endif
        end
      end
      StBusy: begin
        acc_d    = acc_q + addend;
        a_sh_d   = a_sh_q << 2;
        b_sh_d   = b_sh_q >> 2;
        b_prev_d = b_sh_q[1];
        iter_d   = iter_q + CNT_W'(1);
        if (iter_q == CNT_W'(NITER - 1)) state_d = StDone;
      end
      StDone: begin
        if (!out_valid_q) begin
          product_d   = acc_q[PROD_W-1:0];
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      b_prev_q    <= 1'b0;
      iter_q      <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      b_prev_q    <= b_prev_d;
      iter_q      <= iter_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mult_seq_booth.sv
// Self-checking bench for mult_seq_booth: directed WIDTH=16 vectors plus random sweeps.
module tb_mult_seq_booth;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic product of two w-bit operands, reduced modulo 2^(2w).
  function automatic logic [63:0] ref_prod(input int unsigned w, input logic [31:0] x,
                                           input logic [31:0] y, input logic sm);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'({32'd0, x});
    sy = longint'({32'd0, y});
    if (sm && x[w-1]) sx = sx - (longint'(1) << w);
    if (sm && y[w-1]) sy = sy - (longint'(1) << w);
    r = 64'(sx * sy);
    if (2 * w < 64) r = r & ((64'd1 << (2 * w)) - 64'd1);
    return r;
  endfunction

  function automatic int exp_lat(input int unsigned w, input logic zero_op);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    if (zero_op) return 1;
`endif
    return int'(w / 2 + 2);
  endfunction

  // ---------------- Directed WIDTH = 16 instance ----------------
  logic        rst, in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [31:0] product;

  mult_seq_booth #(.WIDTH(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Caller sits at a negedge with the DUT idle. lat = edges after the accept edge.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb, input logic tsm,
                         output int lat, output logic ready_low);
    a = ta; b = tb; signed_mode = tsm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
    lat = 0;
    ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) ready_low = 1'b0;
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handshake_out_valid", 64'(out_valid), 64'd0);
    check("handshake_in_ready", 64'(in_ready), 64'd1);
  endtask

  // ---------------- Random sweeps for WIDTH = 4, 8, 32 ----------------
  localparam int NRAND = 1000;

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned W = (g == 0) ? 4 : (g == 1) ? 8 : 32;
    logic           rst_s, iv, ir, sm, ov, ordy, bz, done;
    logic [W-1:0]   a_s, b_s;
    logic [2*W-1:0] p;

    mult_seq_booth #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst         (rst_s),
      .in_valid    (iv),
      .in_ready    (ir),
      .a           (a_s),
      .b           (b_s),
      .signed_mode (sm),
      .out_valid   (ov),
      .out_ready   (ordy),
      .product     (p),
      .busy        (bz)
    );

    initial begin
      int          lat, stall;
      logic [63:0] expv;
      done = 1'b0;
      rst_s = 1'b1; iv = 1'b0; ordy = 1'b0; sm = 1'b0; a_s = '0; b_s = '0;
      repeat (3) @(negedge clk);
      rst_s = 1'b0;
      @(negedge clk);
      for (int n = 0; n < NRAND; n++) begin
        a_s = W'($urandom); b_s = W'($urandom); sm = 1'($urandom);
        expv = ref_prod(W, 32'(a_s), 32'(b_s), sm);
        check("sweep_in_ready", 64'(ir), 64'd1);
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        lat = exp_lat(W, (a_s == '0) || (b_s == '0));
        a_s = W'($urandom); b_s = W'($urandom);
        stall = 0;
        while (!ov && stall < 100) begin
          @(negedge clk);
          stall++;
        end
        check("sweep_latency", 64'(stall), 64'(lat));
        check("sweep_product", 64'(p), expv & ((2 * W < 64) ? ((64'd1 << (2 * W)) - 1) : '1));
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("sweep_hold_valid", 64'(ov), 64'd1);
          check("sweep_hold_product", 64'(p), expv & ((2 * W < 64) ? ((64'd1 << (2 * W)) - 1) : '1));
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check("sweep_drain", 64'({ov, ir}), 64'b01);
      end
      done = 1'b1;
    end
  end

  // ---------------- Main directed sequence ----------------
  initial begin
    int   lat, guard;
    logic rl;
    vecs[0] = '{16'h2771, 16'h0F67, 1'b0, 32'h025F7D77};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[5] = '{16'h0000, 16'hBEEF, 1'b0, 32'h00000000};
    vecs[6] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vecs[7] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vecs[8] = '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA};
    vecs[9] = '{16'hBEEF, 16'h0000, 1'b1, 32'h00000000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0;
    a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].sm, lat, rl);
      check($sformatf("vec%0d_product", i), 64'(product), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat),
            64'(exp_lat(16, (vecs[i].a == 16'd0) || (vecs[i].b == 16'd0))));
      check($sformatf("vec%0d_in_ready_low", i), 64'(rl), 64'd1);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
      finish_txn();
    end

    // Backpressure: five stalled cycles with a stray in_valid pulse.
    run_txn(16'h1234, 16'h5678, 1'b0, lat, rl);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        a = 16'd7; b = 16'd7; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_product", 64'(product), 64'h06260060);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    finish_txn();
    check("bp_product_after", 64'(product), 64'h06260060);
    @(negedge clk);
    check("bp_pulse_ignored", 64'({busy, out_valid}), 64'd0);

    // Reset during BUSY iteration 4.
    a = 16'hA000; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_product", 64'(product), 64'd0);
    run_txn(16'd3, 16'd5, 1'b0, lat, rl);
    check("after_rst_product", 64'(product), 64'd15);
    check("after_rst_latency", 64'(lat), 64'd10);
    finish_txn();

    guard = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && guard < 90000) begin
      @(negedge clk);
      guard++;
    end
    check("sweep_complete",
          64'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 64'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
